// File: rtl/trap_pkg.sv
// trap_pkg: shared types and constants for the machine-mode trap sequencer
package trap_pkg;
  localparam int XLEN = 64;
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;
  typedef enum logic [1:0] {TRAP, IRQ, RET} kind_t;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
  localparam logic [XLEN-1:0] CAUSE_MTI = 64'h8000_0000_0000_0007;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;
endpackage

// File: rtl/trap_target.sv
// trap_target: redirect target for a trap, interrupt or mret
module trap_target
  import trap_pkg::*;
(
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  kind_t           kind,
  input  logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] target
);
  logic [XLEN-1:0] base;
  logic            unused_cause;
  assign base = {mtvec[XLEN-1:2], 2'b00};
  assign unused_cause = ^cause[XLEN-1:XLEN-2];
  // vectored interrupts land at base + 4*code; the interrupt flag shifts out of the offset
  assign target = kind == RET ? mepc
                : kind == IRQ && mtvec[1:0] == MTVEC_VECTORED ? base + {cause[XLEN-3:0], 2'b00}
                : base;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer driving csrfile trap strobes and the fetch redirect
module trap_ctrl
  import trap_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_exc_valid,
  input  logic [3:0]      i_exc_cause,
  input  logic [XLEN-1:0] i_exc_pc,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_next_pc,
  input  logic            i_pipe_idle,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_mie,
  input  logic [XLEN-1:0] i_mip,
  input  logic            i_mstatus_mie,
  input  logic            i_halted,
  output logic [XLEN-1:0] o_mepc_data,
  output logic            o_mepc_we,
  output logic [XLEN-1:0] o_mcause_data,
  output logic            o_mcause_we,
  output logic            o_mie_clear,
  output logic            o_mie_restore,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc,
  input  logic            i_redirect_ack,
  output logic            o_stall
);
  state_t          state;
  kind_t           kind;
  logic            irq;
  logic            take_exc;
  logic [XLEN-1:0] target;
  logic            unused_csr;
  assign irq = i_mip[7] & i_mie[7] & i_mstatus_mie & ~i_halted;
  assign take_exc = i_exc_valid && (state == IDLE || state == DRAIN);
  assign unused_csr = ^{i_mip[XLEN-1:8], i_mip[6:0], i_mie[XLEN-1:8], i_mie[6:0]};
  trap_target u_target (
    .mtvec  (i_mtvec),
    .mepc   (i_mepc),
    .kind   (kind),
    .cause  (o_mcause_data),
    .target (target)
  );
  // strobes are raised on entry to COMMIT so csrfile sees them for exactly that cycle
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state            <= IDLE;
      kind             <= TRAP;
      o_stall          <= 1'b0;
      o_mepc_we        <= 1'b0;
      o_mcause_we      <= 1'b0;
      o_mie_clear      <= 1'b0;
      o_mie_restore    <= 1'b0;
      o_mepc_data      <= '0;
      o_mcause_data    <= '0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      o_mepc_we     <= 1'b0;
      o_mcause_we   <= 1'b0;
      o_mie_clear   <= 1'b0;
      o_mie_restore <= 1'b0;
      if (take_exc) begin
        kind          <= TRAP;
        o_mcause_data <= {{(XLEN-4){1'b0}}, i_exc_cause};
        o_mepc_data   <= {i_exc_pc[XLEN-1:1], 1'b0};
        o_mepc_we     <= 1'b1;
        o_mcause_we   <= 1'b1;
        o_mie_clear   <= 1'b1;
        o_stall       <= 1'b1;
        state         <= COMMIT;
      end else begin
        case (state)
          IDLE:
            if (i_mret) begin
              kind          <= RET;
              o_mie_restore <= 1'b1;
              o_stall       <= 1'b1;
              state         <= COMMIT;
            end else if (irq) begin
              kind    <= IRQ;
              o_stall <= 1'b1;
              state   <= DRAIN;
            end
          DRAIN:
            if (!irq) begin
              o_stall <= 1'b0;
              state   <= IDLE;
            end else if (i_pipe_idle) begin
              o_mcause_data <= CAUSE_MTI;
              o_mepc_data   <= {i_next_pc[XLEN-1:1], 1'b0};
              o_mepc_we     <= 1'b1;
              o_mcause_we   <= 1'b1;
              o_mie_clear   <= 1'b1;
              state         <= COMMIT;
            end
          COMMIT: begin
            o_redirect_valid <= 1'b1;
            o_redirect_pc    <= target;
            state            <= REDIRECT;
          end
          REDIRECT:
            if (i_redirect_ack) begin
              o_redirect_valid <= 1'b0;
              o_stall          <= 1'b0;
              state            <= IDLE;
            end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven and randomized transaction checks of trap_ctrl against a transaction-level model
module tb_trap_ctrl;
  typedef enum int {K_EXC, K_RET, K_IRQ, K_SPUR, K_HALT, K_PRE, K_ALL} kind_e;
  typedef struct {
    int n_mepc_we, n_mcause_we, n_clear, n_restore;
    logic [63:0] mepc, mcause, rpc;
    int stall, strobe_at, redir_at;
  } obs_t;
  typedef struct {
    kind_e kind;
    logic [3:0] cause;
    logic [63:0] pc, mtvec, mepc, npc;
    int k, ackw;
    obs_t exp;
  } vec_t;
  localparam logic [63:0] MTI = 64'h8000_0000_0000_0007;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic exc_valid, mret, pipe_idle, mstatus_mie, halted, redirect_ack;
  logic [3:0] exc_cause;
  logic [63:0] exc_pc, next_pc, mtvec, mepc, mie, mip;
  logic [63:0] mepc_data, mcause_data, redirect_pc;
  logic mepc_we, mcause_we, mie_clear, mie_restore, redirect_valid, stall;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .i_clk(clk), .i_reset(rst_n), .i_exc_valid(exc_valid), .i_exc_cause(exc_cause),
    .i_exc_pc(exc_pc), .i_mret(mret), .i_next_pc(next_pc), .i_pipe_idle(pipe_idle),
    .i_mtvec(mtvec), .i_mepc(mepc), .i_mie(mie), .i_mip(mip), .i_mstatus_mie(mstatus_mie),
    .i_halted(halted), .o_mepc_data(mepc_data), .o_mepc_we(mepc_we),
    .o_mcause_data(mcause_data), .o_mcause_we(mcause_we), .o_mie_clear(mie_clear),
    .o_mie_restore(mie_restore), .o_redirect_valid(redirect_valid),
    .o_redirect_pc(redirect_pc), .i_redirect_ack(redirect_ack), .o_stall(stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_valid = 1'b0; mret = 1'b0; pipe_idle = 1'b0; mstatus_mie = 1'b0; halted = 1'b0;
    redirect_ack = 1'b0; exc_cause = 4'd0; exc_pc = '0; next_pc = '0; mtvec = '0;
    mepc = '0; mie = '0; mip = '0;
  endtask

  // expected observation of one transaction, from the sequencing rules alone
  function automatic obs_t predict(input vec_t v);
    obs_t o;
    logic [63:0] base;
    o = '{default: 0};
    base = v.mtvec & ~64'd3;
    case (v.kind)
      K_EXC, K_ALL: o = '{1, 1, 1, 0, v.pc & ~64'd1, 64'(v.cause), base, 2 + v.ackw, 1, 2};
      K_PRE: o = '{1, 1, 1, 0, v.pc & ~64'd1, 64'(v.cause), base, v.k + 2 + v.ackw, v.k + 1, v.k + 2};
      K_RET: o = '{0, 0, 0, 1, 64'd0, 64'd0, v.mepc, 2 + v.ackw, 1, 2};
      K_IRQ: o = '{1, 1, 1, 0, v.npc & ~64'd1, MTI,
                   base + ((v.mtvec[1:0] == 2'b01) ? 64'd28 : 64'd0), v.k + 2 + v.ackw, v.k + 1, v.k + 2};
      K_SPUR: o.stall = v.k;
      default: ;
    endcase
    return o;
  endfunction

  task automatic compare(input string tag, input obs_t a, input obs_t e);
    chk({tag, " mepc_we count"}, a.n_mepc_we, e.n_mepc_we);
    chk({tag, " mcause_we count"}, a.n_mcause_we, e.n_mcause_we);
    chk({tag, " mie_clear count"}, a.n_clear, e.n_clear);
    chk({tag, " mie_restore count"}, a.n_restore, e.n_restore);
    chk({tag, " stall cycles"}, a.stall, e.stall);
    chk({tag, " strobe cycle"}, a.strobe_at, e.strobe_at);
    chk({tag, " redirect cycle"}, a.redir_at, e.redir_at);
    if (e.n_mepc_we > 0) begin
      chk({tag, " mepc_data"}, a.mepc, e.mepc);
      chk({tag, " mcause_data"}, a.mcause, e.mcause);
    end
    if (e.redir_at > 0) chk({tag, " redirect_pc"}, a.rpc, e.rpc);
  endtask

  // drives one transaction and records what the DUT did, sampled on falling edges
  task automatic run(input vec_t v, output obs_t o);
    int t = 0;
    int rcnt = 0;
    bit done = 0;
    bit irq_kind = v.kind inside {K_IRQ, K_SPUR, K_HALT, K_PRE, K_ALL};
    o = '{default: 0};
    @(negedge clk);
    mtvec = v.mtvec; mepc = v.mepc; next_pc = v.npc; exc_pc = v.pc; exc_cause = v.cause;
    mip = {$urandom, $urandom} & ~64'h80;
    mie = {$urandom, $urandom} | 64'h80;
    mstatus_mie = irq_kind ? 1'b1 : 1'($urandom);
    if (irq_kind) mip[7] = 1'b1;
    halted = (v.kind == K_HALT);
    exc_valid = v.kind inside {K_EXC, K_ALL};
    mret = v.kind inside {K_RET, K_ALL};
    while (!done) begin
      @(negedge clk);
      t++;
      if (mepc_we) begin o.n_mepc_we++; o.mepc = mepc_data; end
      if (mcause_we) begin o.n_mcause_we++; o.mcause = mcause_data; end
      if (mie_clear) o.n_clear++;
      if (mie_restore) o.n_restore++;
      if ((mepc_we || mie_restore) && o.strobe_at == 0) o.strobe_at = t;
      if (stall) o.stall++;
      if (redirect_valid) begin
        if (o.redir_at == 0) o.redir_at = t;
        o.rpc = redirect_pc;
        rcnt++;
      end
      exc_valid = (v.kind == K_PRE && stall && o.stall == v.k);
      mret = 1'b0;
      pipe_idle = (v.kind == K_IRQ && stall && o.stall == v.k);
      if (v.kind == K_SPUR && stall && o.stall == v.k) mstatus_mie = 1'b0;
      if (mepc_we || mie_restore || redirect_valid) mip[7] = 1'b0;
      redirect_ack = redirect_valid && rcnt > v.ackw;
      done = (t >= (v.kind == K_HALT ? 6 : 1)) && !stall;
      if (t > 60) begin
        checks++;
        errors++;
        $display("FAIL timeout: transaction still stalled after %0d cycles", t);
        done = 1;
      end
    end
    clear_inputs();
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    obs_t got;
    logic [3:0] causes[3];
    int strobes;
    causes = '{4'd2, 4'd3, 4'd11};
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("reset stall", stall, 0);
    chk("reset redirect_valid", redirect_valid, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    chk("reset mepc_data", mepc_data, 0);
    chk("reset mcause_data", mcause_data, 0);
    chk("reset strobes", {mepc_we, mcause_we, mie_clear, mie_restore}, 0);
    rst_n = 1'b1;

    tbl[0] = '{K_EXC, 4'd2, 64'h8000_0044, 64'h8000_0100, 64'd0, 64'd0, 0, 0,
               '{1, 1, 1, 0, 64'h8000_0044, 64'd2, 64'h8000_0100, 2, 1, 2}};
    tbl[1] = '{K_IRQ, 4'd0, 64'd0, 64'h8000_0101, 64'd0, 64'h8000_0200, 3, 0,
               '{1, 1, 1, 0, 64'h8000_0200, MTI, 64'h8000_011C, 5, 4, 5}};
    tbl[2] = '{K_RET, 4'd0, 64'd0, 64'h8000_0100, 64'h8000_0048, 64'd0, 0, 0,
               '{0, 0, 0, 1, 64'd0, 64'd0, 64'h8000_0048, 2, 1, 2}};
    tbl[3] = '{K_ALL, 4'd11, 64'h8000_0050, 64'h8000_0100, 64'h8000_0048, 64'h8000_0200, 0, 0,
               '{1, 1, 1, 0, 64'h8000_0050, 64'd11, 64'h8000_0100, 2, 1, 2}};
    tbl[4] = '{K_SPUR, 4'd0, 64'd0, 64'h8000_0101, 64'd0, 64'h8000_0200, 2, 0,
               '{0, 0, 0, 0, 64'd0, 64'd0, 64'd0, 2, 0, 0}};
    tbl[5] = '{K_HALT, 4'd0, 64'd0, 64'h8000_0101, 64'd0, 64'h8000_0200, 2, 0,
               '{0, 0, 0, 0, 64'd0, 64'd0, 64'd0, 0, 0, 0}};
    tbl[6] = '{K_EXC, 4'd3, 64'h8000_0067, 64'h8000_0103, 64'd0, 64'd0, 0, 2,
               '{1, 1, 1, 0, 64'h8000_0066, 64'd3, 64'h8000_0100, 4, 1, 2}};
    tbl[7] = '{K_IRQ, 4'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0, 64'h1001, 1, 1,
               '{1, 1, 1, 0, 64'h1000, MTI, 64'h000C, 4, 2, 3}};
    tbl[8] = '{K_PRE, 4'd11, 64'h400, 64'h2000_0001, 64'd0, 64'h900, 2, 0,
               '{1, 1, 1, 0, 64'h400, 64'd11, 64'h2000_0000, 4, 3, 4}};
    tbl[9] = '{K_IRQ, 4'd0, 64'd0, 64'h3000_0002, 64'd0, 64'h5000, 1, 0,
               '{1, 1, 1, 0, 64'h5000, MTI, 64'h3000_0000, 3, 2, 3}};
    for (int i = 0; i < 10; i++) begin
      run(tbl[i], got);
      compare($sformatf("vec%0d", i), got, tbl[i].exp);
    end

    // ack held high from acceptance: only the REDIRECT cycle may consume it
    @(negedge clk);
    mtvec = 64'h8000_0100; exc_pc = 64'h10; exc_cause = 4'd2; exc_valid = 1'b1; redirect_ack = 1'b1;
    @(negedge clk);
    exc_valid = 1'b0;
    chk("early_ack commit stall", stall, 1);
    chk("early_ack commit redirect_valid", redirect_valid, 0);
    @(negedge clk);
    chk("early_ack redirect_valid", redirect_valid, 1);
    @(negedge clk);
    chk("early_ack back idle", stall, 0);
    redirect_ack = 1'b0;

    // reset in the middle of REDIRECT clears every output at once
    exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 64'h20;
    @(negedge clk);
    exc_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid redirect_valid before", redirect_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid stall", stall, 0);
    chk("rst_mid redirect_valid", redirect_valid, 0);
    chk("rst_mid redirect_pc", redirect_pc, 0);
    chk("rst_mid mepc_data", mepc_data, 0);
    chk("rst_mid mcause_data", mcause_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid idle stall", stall, 0);
    chk("rst_mid idle redirect", redirect_valid, 0);

    // reset during DRAIN leaves csrfile untouched
    mip = 64'h80; mie = 64'h80; mstatus_mie = 1'b1; next_pc = 64'h300;
    @(negedge clk);
    chk("rst_drain in drain", stall, 1);
    rst_n = 1'b0;
    pipe_idle = 1'b1;
    #1;
    chk("rst_drain stall", stall, 0);
    mip = '0;
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    repeat (3) begin
      @(negedge clk);
      if (mepc_we || mcause_we || mie_clear || mie_restore || redirect_valid) strobes++;
    end
    chk("rst_drain no strobe", strobes, 0);
    chk("rst_drain mepc_data", mepc_data, 0);
    clear_inputs();

    for (int i = 0; i < 200; i++) begin
      v.kind = kind_e'($urandom_range(0, 6));
      v.cause = causes[$urandom_range(0, 2)];
      v.pc = {$urandom, $urandom};
      v.mtvec = {$urandom, $urandom};
      v.mepc = {$urandom, $urandom};
      v.npc = {$urandom, $urandom};
      v.k = $urandom_range(1, 5);
      v.ackw = $urandom_range(0, 3);
      v.exp = predict(v);
      run(v, got);
      compare($sformatf("rnd%0d", i), got, v.exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the execute/commit stage and `csrfile`. It arbitrates synchronous exceptions, the machine timer interrupt and `mret`, and drives the `csrfile` write strobes (`mepc`, `mcause`, MIE clear/restore). It then issues a single PC redirect with flush to fetch. It reads `mtvec`, `mepc`, `mie`, `mip` and `mstatus.MIE` back from `csrfile`. It is the only writer of the `csrfile` trap strobes.

## Interface
- `XLEN`, 64: datapath width.
- `i_clk`  in  1: core clock. Rising edge here; `csrfile` samples on the falling edge.
- `i_reset`  in  1: asynchronous, active-low reset.
- `i_exc_valid`  in  1: commit stage reports a synchronous exception this cycle.
- `i_exc_cause`  in  4: exception code (2 illegal, 3 breakpoint, 11 ecall-M).
- `i_exc_pc`  in  XLEN: PC of the faulting instruction.
- `i_mret`  in  1: `mret` committing this cycle.
- `i_next_pc`  in  XLEN: PC of the oldest uncommitted instruction; used as `mepc` for interrupts.
- `i_pipe_idle`  in  1: pipeline drained, with no instruction in flight past decode.
- `i_mtvec`, `i_mepc`, `i_mie`, `i_mip`  in  XLEN each: readback from `csrfile`.
- `i_mstatus_mie`  in  1: global interrupt enable.
- `i_halted`  in  1: debug halt; masks interrupts.
- `o_mepc_data`  out  XLEN, `o_mepc_we`  out  1: `mepc` write.
- `o_mcause_data`  out  XLEN, `o_mcause_we`  out  1: `mcause` write.
- `o_mie_clear`, `o_mie_restore`  out  1 each: MIE stack push / pop.
- `o_redirect_valid`  out  1, `o_redirect_pc`  out  XLEN: PC redirect with flush.
- `i_redirect_ack`  in  1: fetch accepted the redirect.
- `o_stall`  out  1: hold commit; asserted in every state except IDLE.

## Operation
- Interrupt pending: `irq = i_mip[7] & i_mie[7] & i_mstatus_mie & ~i_halted`.
- Priority in IDLE: exception > mret > irq. Lower-priority events in the same cycle are dropped. Their sources re-present them, since `o_stall` holds commit.
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT.
  - IDLE, exception: latch cause {1'b0, 59'b0, cause}, epc = `i_exc_pc`, kind = TRAP. Go to COMMIT.
  - IDLE, mret: latch kind = RET. Go to COMMIT.
  - IDLE, irq: latch cause `64'h8000_0000_0000_0007`, kind = IRQ. Go to DRAIN.
  - DRAIN: wait for `i_pipe_idle`. On that cycle latch epc = `i_next_pc` and go to COMMIT.
  - DRAIN re-checks `irq` each cycle. If `irq` drops, return to IDLE with no side effects (spurious cancel).
  - DRAIN also honours `i_exc_valid`: the exception pre-empts the interrupt and is taken as in IDLE.
  - COMMIT, one cycle:
    - TRAP/IRQ: pulse `o_mepc_we`, `o_mcause_we`, `o_mie_clear`.
    - RET: pulse `o_mie_restore` only.
    - Compute target into the redirect register. Go to REDIRECT.
  - REDIRECT: hold `o_redirect_valid` and `o_redirect_pc` until `i_redirect_ack`, then go to IDLE.
- Target:
  - TRAP: `{mtvec[63:2],2'b00}`.
  - IRQ: base + 4×7 if `mtvec[1:0]==2'b01` (vectored), else base.
  - RET: `i_mepc`, sampled in COMMIT.
  - Sum is XLEN-bit, wrapping modulo 2^64.
- `o_mepc_data` bit 0 is forced to 0.
- Strobes are single-cycle registered pulses. Never two COMMITs without an intervening IDLE.

## Timing
- Reset (async assert, sync release): state IDLE.
  - All outputs 0: `o_stall`, strobes, `o_redirect_valid`, `o_redirect_pc`, `o_mepc_data`, `o_mcause_data`.
- Exception or mret accepted on edge N:
  - `o_stall`=1 from N.
  - Strobes high N→N+1, captured by `csrfile` on the falling edge inside that cycle.
  - `o_redirect_valid`=1 from N+1.
  - Zero-wait ack gives IDLE at N+2.
- IRQ: DRAIN for k cycles until idle, then COMMIT, then REDIRECT. Minimum 3 cycles to IDLE.
- `i_redirect_ack` outside REDIRECT is ignored.
- Reset mid-sequence aborts with no strobe. If reset lands before COMMIT, `csrfile` stays untouched.

## Structure
- Shared package `trap_pkg`:
  - state enum {IDLE, DRAIN, COMMIT, REDIRECT}.
  - kind enum {TRAP, IRQ, RET}.
  - cause constants `CAUSE_ILLEGAL=2`, `CAUSE_BREAK=3`, `CAUSE_ECALL_M=11`, `CAUSE_MTI=64'h8000_0000_0000_0007`.
  - `MTVEC_VECTORED=2'b01`.
- One sub-module, `trap_target`: combinational target calculation from mtvec/mepc/kind/cause.

## Test plan
- Reset low mid-REDIRECT → all outputs 0 immediately, state IDLE after release.
- mtvec=`0x8000_0100`, exception cause 2 at pc `0x8000_0044`, ack same cycle:
  - N+0→N+1: `o_mepc_data`=`0x8000_0044`, `o_mcause_data`=2, `o_mepc_we`/`o_mcause_we`/`o_mie_clear` high.
  - From N+1: `o_redirect_pc`=`0x8000_0100`, IDLE at N+2.
- mtvec=`0x8000_0101`, mip[7]=mie[7]=MIE=1, `i_pipe_idle` after 3 cycles, next_pc=`0x8000_0200`:
  - mcause=`0x8000_0000_0000_0007`, mepc=`0x8000_0200`, redirect `0x8000_011C`.
- mret with mepc=`0x8000_0048` → only `o_mie_restore` pulses, redirect `0x8000_0048`.
- Simultaneous `i_exc_valid`(cause 11) + `i_mret` + irq → trap taken with cause 11. No `o_mie_restore` pulse.
- Irq raised, then MIE cleared during DRAIN → return to IDLE, no strobe, no redirect. Same stimulus with `i_halted`=1 → never leaves IDLE.
